// File: rtl/axis_multiq_admit.sv
// Multi-queue AXI4-Stream ingress admission: steers packets to per-queue FIFOs
// by a tuser queue id and admits whole packets against per-queue word credits.
module axis_multiq_admit #(
  parameter int TDATA_BYTES  = 8,
  parameter int TUSER_WIDTH  = 128,
  parameter int NUM_QUEUES   = 4,
  parameter int QID_WIDTH    = 2,
  parameter int QID_LSB      = 24,
  parameter int WORD_LOG2    = 3,
  parameter int CREDIT_WIDTH = 18,
  parameter int QUEUE_WORDS  = 131072,
  parameter int DROP_MODE    = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic                                        s_tvalid,
  output logic                                        s_tready,
  input  logic [8*TDATA_BYTES-1:0]                    s_tdata,
  input  logic [TDATA_BYTES-1:0]                      s_tkeep,
  input  logic                                        s_tlast,
  input  logic [TUSER_WIDTH-1:0]                      s_tuser,
  output logic                                        fifo_wr_en,
  output logic [8*TDATA_BYTES+TDATA_BYTES+QID_WIDTH:0] fifo_wr_data,
  input  logic                                        fifo_full,
  input  logic                                        ret_valid,
  input  logic [QID_WIDTH-1:0]                        ret_qid,
  output logic [NUM_QUEUES*CREDIT_WIDTH-1:0]          credit,
  output logic [31:0]                                 pkt_cnt,
  output logic [31:0]                                 drop_cnt,
  output logic [31:0]                                 oversize_cnt,
  output logic [1:0]                                  dbg_state
);
  localparam int CW = CREDIT_WIDTH;
  localparam logic [1:0] ST_SOP  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Handshake: a beat moves only in a cycle where s_tvalid and s_tready are
  // both high; s_tready never depends on s_tvalid, and fifo_wr_en is that same
  // transfer qualified by "beat is written" with no added latency.

  logic [1:0]           r_state;
  logic [QID_WIDTH-1:0] r_qid;
  logic [CW-1:0]        r_need;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_credit [NUM_QUEUES];
  logic [31:0]          r_pkt_cnt, r_drop_cnt, r_ovs_cnt;

  logic [QID_WIDTH-1:0] w_qid;
  logic [CW-1:0]        w_need;
  logic                 w_qid_ok;
  logic [CW-1:0]        w_sel_credit;
  logic                 w_fit;
  logic [CW-1:0]        w_cnt_inc;
  logic                 w_unused;

  logic [1:0]           w_state_nx;
  logic [CW-1:0]        w_cnt_nx;
  logic                 w_wr, w_last, w_res, w_ref, w_latch;
  logic                 w_inc_pkt, w_inc_drop, w_inc_ovs;
  logic [QID_WIDTH-1:0] w_out_qid, w_ref_qid;
  logic [CW-1:0]        w_ref_amt;
  logic [CW:0]          w_sum       [NUM_QUEUES];
  logic [CW-1:0]        w_credit_nx [NUM_QUEUES];

  assign w_qid     = s_tuser[QID_LSB +: QID_WIDTH];
  assign w_need    = CW'(s_tuser[15:WORD_LOG2]) + CW'(1);
  assign w_qid_ok  = 32'(w_qid) < 32'(NUM_QUEUES);
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_unused  = ^s_tuser;

  always_comb begin
    w_sel_credit = '0;
    for (int q = 0; q < NUM_QUEUES; q++)
      if (w_qid == QID_WIDTH'(q)) w_sel_credit = r_credit[q];
  end

  assign w_fit = w_qid_ok && (w_sel_credit >= w_need);

  always_comb begin
    s_tready   = 1'b0;
    w_wr       = 1'b0;
    w_last     = s_tlast;
    w_out_qid  = r_qid;
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_res      = 1'b0;
    w_ref      = 1'b0;
    w_ref_amt  = '0;
    w_ref_qid  = r_qid;
    w_latch    = 1'b0;
    w_inc_pkt  = 1'b0;
    w_inc_drop = 1'b0;
    w_inc_ovs  = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_SOP: begin
          s_tready  = enable && !fifo_full && ((DROP_MODE != 0) || w_fit);
          w_out_qid = w_qid;
          if (s_tvalid && s_tready) begin
            if (w_fit) begin
              w_wr      = 1'b1;
              w_res     = 1'b1;
              w_latch   = 1'b1;
              w_inc_pkt = 1'b1;
              w_cnt_nx  = CW'(1);
              if (s_tlast) begin
                // single-beat packet: reserve and refund net out in one update
                w_ref     = 1'b1;
                w_ref_amt = w_need - CW'(1);
                w_ref_qid = w_qid;
              end else if (w_need == CW'(1)) begin
                w_last     = 1'b1;
                w_inc_ovs  = 1'b1;
                w_state_nx = ST_DROP;
              end else begin
                w_state_nx = ST_PASS;
              end
            end else begin
              w_inc_drop = 1'b1;
              w_state_nx = s_tlast ? ST_SOP : ST_DROP;
            end
          end
        end
        ST_PASS: begin
          s_tready = enable && !fifo_full;
          if (s_tvalid && s_tready) begin
            w_wr     = 1'b1;
            w_cnt_nx = w_cnt_inc;
            w_last   = s_tlast || (w_cnt_inc == r_need);
            if (s_tlast) begin
              w_ref      = 1'b1;
              w_ref_amt  = r_need - w_cnt_inc;
              w_state_nx = ST_SOP;
            end else if (w_cnt_inc == r_need) begin
              w_inc_ovs  = 1'b1;
              w_state_nx = ST_DROP;
            end
          end
        end
        ST_DROP: begin
          s_tready = enable;
          if (s_tvalid && s_tready && s_tlast) w_state_nx = ST_SOP;
        end
        default: w_state_nx = ST_SOP;
      endcase
    end
  end

  // Additions before the subtraction; a reserve is only issued when it fits.
  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      w_sum[q] = {1'b0, r_credit[q]};
      if (w_ref && (w_ref_qid == QID_WIDTH'(q))) w_sum[q] = w_sum[q] + {1'b0, w_ref_amt};
      if (ret_valid && (ret_qid == QID_WIDTH'(q))) w_sum[q] = w_sum[q] + (CW+1)'(1);
      if (w_res && (w_qid == QID_WIDTH'(q))) w_sum[q] = w_sum[q] - {1'b0, w_need};
      w_credit_nx[q] = (w_sum[q] > (CW+1)'(QUEUE_WORDS)) ? CW'(QUEUE_WORDS) : w_sum[q][CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_SOP;
      r_qid     <= '0;
      r_need    <= '0;
      r_cnt     <= '0;
      r_pkt_cnt <= '0;
      r_drop_cnt <= '0;
      r_ovs_cnt <= '0;
      for (int q = 0; q < NUM_QUEUES; q++) r_credit[q] <= CW'(QUEUE_WORDS);
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_latch) begin
        r_qid  <= w_qid;
        r_need <= w_need;
      end
      for (int q = 0; q < NUM_QUEUES; q++) r_credit[q] <= w_credit_nx[q];
      if (w_inc_pkt)  r_pkt_cnt  <= r_pkt_cnt + 32'd1;
      if (w_inc_drop) r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_inc_ovs)  r_ovs_cnt  <= r_ovs_cnt + 32'd1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_QUEUES; g++) begin : g_credit
      assign credit[g*CW +: CW] = r_credit[g];
    end
  endgenerate

  assign fifo_wr_en   = w_wr;
  assign fifo_wr_data = {w_out_qid, s_tkeep, s_tdata, w_last};
  assign pkt_cnt      = r_pkt_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign oversize_cnt = r_ovs_cnt;
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_axis_multiq_admit.sv
// Bench for axis_multiq_admit: one drop-mode and one stall-mode instance on a
// shared stream, with a small per-queue capacity so credit exhaustion is quick.
module tb_axis_multiq_admit;
  localparam int QW = 64;
  localparam int CW = 18;
  localparam int W  = 75;

  logic clk = 1'b0;
  logic reset, enable;
  logic s_tvalid_a, s_tvalid_b, s_tready_a, s_tready_b;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tkeep;
  logic         s_tlast;
  logic [127:0] s_tuser;
  logic         wr_en_a, wr_en_b, fifo_full;
  logic [W-1:0] wr_data_a, wr_data_b;
  logic         ret_valid_a, ret_valid_b;
  logic [1:0]   ret_qid;
  logic [4*CW-1:0] credit_a, credit_b;
  logic [31:0]  pkt_a, drop_a, ovs_a, pkt_b, drop_b, ovs_b;
  logic [1:0]   dbg_a, dbg_b;

  axis_multiq_admit #(.QUEUE_WORDS(QW), .DROP_MODE(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .s_tvalid(s_tvalid_a), .s_tready(s_tready_a),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .fifo_wr_en(wr_en_a), .fifo_wr_data(wr_data_a), .fifo_full(fifo_full),
    .ret_valid(ret_valid_a), .ret_qid(ret_qid), .credit(credit_a),
    .pkt_cnt(pkt_a), .drop_cnt(drop_a), .oversize_cnt(ovs_a), .dbg_state(dbg_a));

  axis_multiq_admit #(.QUEUE_WORDS(QW), .DROP_MODE(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .s_tvalid(s_tvalid_b), .s_tready(s_tready_b),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .fifo_wr_en(wr_en_b), .fifo_wr_data(wr_data_b), .fifo_full(fifo_full),
    .ret_valid(ret_valid_b), .ret_qid(ret_qid), .credit(credit_b),
    .pkt_cnt(pkt_b), .drop_cnt(drop_b), .oversize_cnt(ovs_b), .dbg_state(dbg_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  int stall_cycles = 0;
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  typedef struct {
    int len; int nbeats; int qid;
    int exp_wr; int exp_sop_cred; int exp_cred; int exp_pkt; int exp_ovs;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cred_of(input int sel, input int q);
    if (sel == 2) return 32'(credit_b[q*CW +: CW]);
    return 32'(credit_a[q*CW +: CW]);
  endfunction

  function automatic logic ready_of(input int sel);
    if (sel == 1) return s_tready_a;
    if (sel == 2) return s_tready_b;
    return s_tready_a & s_tready_b;
  endfunction

  // Scoreboard: every written beat must match the head of its expected queue.
  always @(negedge clk) begin
    if (wr_en_a) begin
      wr_cnt_a++;
      checks++;
      if (exp_q_a.size() == 0) begin
        errors++;
        $display("FAIL wr_a_unexpected: got %h expected no write", wr_data_a);
      end else begin
        logic [W-1:0] e;
        e = exp_q_a.pop_front();
        if (wr_data_a !== e) begin
          errors++;
          $display("FAIL wr_a_data: got %h expected %h", wr_data_a, e);
        end
      end
    end
    if (wr_en_b) begin
      wr_cnt_b++;
      checks++;
      if (exp_q_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b_unexpected: got %h expected no write", wr_data_b);
      end else begin
        logic [W-1:0] e;
        e = exp_q_b.pop_front();
        if (wr_data_b !== e) begin
          errors++;
          $display("FAIL wr_b_data: got %h expected %h", wr_data_b, e);
        end
      end
    end
  end

  // Drives one packet; beats at or below need are expected on the write port
  // when the packet is admitted, with last forced on the need-th beat.
  task automatic send_pkt(input int sel, input int len, input int nbeats, input int qid,
                          input bit adm, input int hold_at, input int hold_cyc,
                          input bit ret_at_sop, input int abort_at,
                          output logic [31:0] sop_cred);
    int need;
    logic [127:0] u;
    logic [63:0] d;
    logic [7:0] k;
    logic r, got;
    need = (len >> 3) + 1;
    sop_cred = '0;
    u = '0;
    u[15:0] = 16'(len);
    u[24 +: 2] = 2'(qid);
    for (int i = 1; i <= nbeats; i++) begin
      if (i == abort_at) break;
      d = {$urandom, $urandom};
      k = (i == nbeats) ? 8'($urandom_range(1, 255)) : 8'hFF;
      s_tdata = d;
      s_tkeep = k;
      s_tlast = (i == nbeats);
      s_tuser = u;
      s_tvalid_a = (sel != 2);
      s_tvalid_b = (sel != 1);
      if (adm && i <= need) begin
        if (sel != 2) exp_q_a.push_back({2'(qid), k, d, (i == nbeats) || (i == need)});
        if (sel != 1) exp_q_b.push_back({2'(qid), k, d, (i == nbeats) || (i == need)});
      end
      if (i == hold_at) begin
        fifo_full = 1'b1;
        for (int h = 0; h < hold_cyc; h++) begin
          @(negedge clk);
          check("full_ready_low", 32'(ready_of(sel)), 32'd0);
          @(posedge clk); #1;
        end
        fifo_full = 1'b0;
      end
      if (i == 1 && ret_at_sop) begin
        ret_valid_a = 1'b1;
        ret_qid = 2'(qid);
      end
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        r = ready_of(sel);
        @(posedge clk); #1;
        if (r) begin got = 1'b1; break; end
        stall_cycles++;
      end
      ret_valid_a = 1'b0;
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got no ready in 200 cycles expected transfer of beat %0d", i);
        break;
      end
      if (i == 1) sop_cred = cred_of(sel == 2 ? 2 : 1, qid);
    end
    s_tvalid_a = 1'b0;
    s_tvalid_b = 1'b0;
    s_tlast = 1'b0;
  endtask

  initial begin
    logic [31:0] sc;
    int w0;
    tbl[0] = '{len: 64,  nbeats: 8,  qid: 1, exp_wr: 8,  exp_sop_cred: 55, exp_cred: 56, exp_pkt: 1, exp_ovs: 0};
    tbl[1] = '{len: 16,  nbeats: 6,  qid: 3, exp_wr: 3,  exp_sop_cred: 61, exp_cred: 61, exp_pkt: 2, exp_ovs: 1};
    tbl[2] = '{len: 0,   nbeats: 1,  qid: 0, exp_wr: 1,  exp_sop_cred: 63, exp_cred: 63, exp_pkt: 3, exp_ovs: 1};
    tbl[3] = '{len: 100, nbeats: 13, qid: 0, exp_wr: 13, exp_sop_cred: 50, exp_cred: 50, exp_pkt: 4, exp_ovs: 1};
    tbl[4] = '{len: 24,  nbeats: 2,  qid: 3, exp_wr: 2,  exp_sop_cred: 57, exp_cred: 59, exp_pkt: 5, exp_ovs: 1};
    tbl[5] = '{len: 40,  nbeats: 5,  qid: 1, exp_wr: 5,  exp_sop_cred: 50, exp_cred: 51, exp_pkt: 6, exp_ovs: 1};

    reset = 1'b1; enable = 1'b1; fifo_full = 1'b0;
    s_tvalid_a = 1'b0; s_tvalid_b = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
    ret_valid_a = 1'b0; ret_valid_b = 1'b0; ret_qid = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_tready", 32'(s_tready_a), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int q = 0; q < 4; q++) check("reset_credit", cred_of(1, q), QW);
    check("reset_pkt", pkt_a, 0);
    check("reset_drop", drop_a, 0);
    check("reset_ovs", ovs_a, 0);
    check("idle_tready", 32'(s_tready_a), 32'd1);
    @(posedge clk); #1;

    for (int r = 0; r < 6; r++) begin
      w0 = wr_cnt_a;
      send_pkt(1, tbl[r].len, tbl[r].nbeats, tbl[r].qid, 1'b1, 0, 0, 1'b0, 0, sc);
      @(negedge clk);
      check("tbl_writes", 32'(wr_cnt_a - w0), tbl[r].exp_wr);
      check("tbl_sop_credit", sc, tbl[r].exp_sop_cred);
      check("tbl_credit", cred_of(1, tbl[r].qid), tbl[r].exp_cred);
      check("tbl_pkt", pkt_a, tbl[r].exp_pkt);
      check("tbl_ovs", ovs_a, tbl[r].exp_ovs);
      check("tbl_state_sop", 32'(dbg_a), 32'd0);
      @(posedge clk); #1;
    end

    // Backpressure mid-packet plus a returned word during the SOP cycle.
    w0 = wr_cnt_a;
    send_pkt(1, 64, 8, 3, 1'b1, 3, 4, 1'b1, 0, sc);
    @(negedge clk);
    check("full_sop_credit", sc, 51);
    check("full_credit", cred_of(1, 3), 52);
    check("full_writes", 32'(wr_cnt_a - w0), 8);
    check("full_pkt", pkt_a, 7);
    @(posedge clk); #1;

    for (int n = 0; n < QW - 5; n++) send_pkt(3, 0, 1, 2, 1'b1, 0, 0, 1'b0, 0, sc);
    @(negedge clk);
    check("fill_credit_a", cred_of(1, 2), 5);
    check("fill_credit_b", cred_of(2, 2), 5);
    check("fill_pkt_a", pkt_a, 7 + QW - 5);
    check("fill_pkt_b", pkt_b, QW - 5);
    @(posedge clk); #1;

    w0 = wr_cnt_a;
    stall_cycles = 0;
    send_pkt(1, 64, 8, 2, 1'b0, 0, 0, 1'b0, 0, sc);
    @(negedge clk);
    check("drop_stalls", 32'(stall_cycles), 0);
    check("drop_writes", 32'(wr_cnt_a - w0), 0);
    check("drop_cnt", drop_a, 1);
    check("drop_credit", cred_of(1, 2), 5);
    check("drop_pkt", pkt_a, 7 + QW - 5);
    @(posedge clk); #1;

    // Stall mode: head packet waits until four returns raise credit to nine.
    s_tuser = '0;
    s_tuser[15:0] = 16'd64;
    s_tuser[24 +: 2] = 2'd2;
    s_tlast = 1'b0;
    s_tvalid_b = 1'b1;
    ret_qid = 2'd2;
    ret_valid_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_ready_low", 32'(s_tready_b), 32'd0);
      @(posedge clk); #1;
    end
    ret_valid_b = 1'b0;
    check("stall_credit_9", cred_of(2, 2), 9);
    w0 = wr_cnt_b;
    stall_cycles = 0;
    send_pkt(2, 64, 8, 2, 1'b1, 0, 0, 1'b0, 0, sc);
    @(negedge clk);
    check("stall_no_extra_wait", 32'(stall_cycles), 0);
    check("stall_sop_credit", sc, 0);
    check("stall_credit", cred_of(2, 2), 1);
    check("stall_writes", 32'(wr_cnt_b - w0), 8);
    check("stall_pkt_b", pkt_b, QW - 5 + 1);
    check("stall_drop_b", drop_b, 0);
    @(posedge clk); #1;

    // Reset with two of eight beats written abandons the packet.
    send_pkt(1, 64, 8, 1, 1'b1, 0, 0, 1'b0, 3, sc);
    s_tvalid_a = 1'b1;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mid_reset_tready", 32'(s_tready_a), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    s_tvalid_a = 1'b0;
    @(negedge clk);
    for (int q = 0; q < 4; q++) check("rst_credit_a", cred_of(1, q), QW);
    check("rst_credit_b2", cred_of(2, 2), QW);
    check("rst_pkt", pkt_a, 0);
    check("rst_drop", drop_a, 0);
    check("rst_ovs", ovs_a, 0);
    check("rst_state", 32'(dbg_a), 32'd0);
    @(posedge clk); #1;
    w0 = wr_cnt_a;
    send_pkt(1, 64, 8, 1, 1'b1, 0, 0, 1'b0, 0, sc);
    @(negedge clk);
    check("post_rst_sop_credit", sc, QW - 9);
    check("post_rst_credit", cred_of(1, 1), QW - 8);
    check("post_rst_writes", 32'(wr_cnt_a - w0), 8);
    check("post_rst_pkt", pkt_a, 1);

    repeat (2) @(posedge clk);
    check("exp_q_a_empty", 32'(exp_q_a.size()), 0);
    check("exp_q_b_empty", 32'(exp_q_b.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
